// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcode constants, default widths, entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_rs_pkg;

    localparam int RS_DEPTH  = 4;
    localparam int RS_TAG_W  = 4;
    localparam int RS_DATA_W = 32;
    localparam int ALUC_W    = 4;

    // ALU opcode encoding; the station never decodes these, it only carries them.
    typedef enum logic [ALUC_W-1:0] {
        ALUC_ADDU = 4'b0000,
        ALUC_SUBU = 4'b0001,
        ALUC_ADD  = 4'b0010,
        ALUC_SUB  = 4'b0011,
        ALUC_AND  = 4'b0100,
        ALUC_OR   = 4'b0101,
        ALUC_XOR  = 4'b0110,
        ALUC_NOR  = 4'b0111,
        ALUC_LUI  = 4'b1000,
        ALUC_SLTU = 4'b1010,
        ALUC_SLT  = 4'b1011,
        ALUC_SRL  = 4'b1101,
        ALUC_SLL  = 4'b1110,
        ALUC_SRA  = 4'b1111
    } aluc_e;

    // Entry layout at the default widths. The station declares the same
    // layout locally so it can follow its TAG_W/DATA_W parameters.
    typedef struct packed {
        logic                 busy;
        logic [ALUC_W-1:0]    aluc;
        logic [RS_TAG_W-1:0]  dst;
        logic                 rdy1;
        logic [RS_DATA_W-1:0] val1;
        logic [RS_TAG_W-1:0]  tag1;
        logic                 rdy2;
        logic [RS_DATA_W-1:0] val2;
        logic [RS_TAG_W-1:0]  tag2;
    } rs_entry_t;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority picker: one-hot grant of the lowest set request bit.
// Latency: combinational.
// Backpressure: none; grant follows the request vector directly.
// Ports: req (N request bits), gnt (one-hot grant, zero when no request), vld (any request).
module rs_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         vld
);

    always_comb begin
        gnt = '0;
        // Scan from the top so the last hit (lowest index) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds dispatched ops, wakes operands from the CDB, issues the lowest ready op.
// Latency: dispatch->issue 1 cycle; wakeup->issue 1 cycle (0 cycles when ALU_RS_FWD_EN is defined).
// Backpressure: disp_ready drops when all entries are busy; iss_* held while iss_valid && !iss_ready (unless a lower entry becomes eligible).
// Ports: clk/rst (sync, active-high)/flush; disp_* dispatch input with valid/ready;
//        cdb_* result broadcast; iss_* issue output with valid/ready.
// Optional feature macro: ALU_RS_FWD_EN (CDB value forwarded straight into the issue mux).
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH  = RS_DEPTH,
    parameter int TAG_W  = RS_TAG_W,
    parameter int DATA_W = RS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [3:0]        disp_aluc,
    input  logic [TAG_W-1:0]  disp_dst,
    input  logic              disp_rdy1,
    input  logic              disp_rdy2,
    input  logic [DATA_W-1:0] disp_val1,
    input  logic [DATA_W-1:0] disp_val2,
    input  logic [TAG_W-1:0]  disp_tag1,
    input  logic [TAG_W-1:0]  disp_tag2,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [DATA_W-1:0] iss_src1,
    output logic [DATA_W-1:0] iss_src2,
    output logic [3:0]        iss_aluc,
    output logic [TAG_W-1:0]  iss_dst
);

    typedef struct packed {
        logic              busy;
        logic [ALUC_W-1:0] aluc;
        logic [TAG_W-1:0]  dst;
        logic              rdy1;
        logic [DATA_W-1:0] val1;
        logic [TAG_W-1:0]  tag1;
        logic              rdy2;
        logic [DATA_W-1:0] val2;
        logic [TAG_W-1:0]  tag2;
    } ent_t;

    ent_t ent_q [DEPTH];

    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] free_gnt;
    logic [DEPTH-1:0] iss_gnt;
    logic             free_vld;
    logic             iss_any;
    logic             disp_fire;
    logic             iss_fire;
    logic             cap1;
    logic             cap2;
    logic [DATA_W-1:0] capval1;
    logic [DATA_W-1:0] capval2;

    // Per-entry CDB tag match and eligibility.
    always_comb begin
        busy_vec = '0;
        hit1     = '0;
        hit2     = '0;
        elig     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i] = ent_q[i].busy;
            hit1[i] = cdb_valid && ent_q[i].busy && !ent_q[i].rdy1 && (ent_q[i].tag1 == cdb_tag);
            hit2[i] = cdb_valid && ent_q[i].busy && !ent_q[i].rdy2 && (ent_q[i].tag2 == cdb_tag);
`ifdef ALU_RS_FWD_EN
            elig[i] = ent_q[i].busy && (ent_q[i].rdy1 || hit1[i]) && (ent_q[i].rdy2 || hit2[i]);
`else
            elig[i] = ent_q[i].busy && ent_q[i].rdy1 && ent_q[i].rdy2;
`endif
        end
    end

    rs_pick #(.N(DEPTH)) u_free_pick (
        .req (~busy_vec),
        .gnt (free_gnt),
        .vld (free_vld)
    );

    rs_pick #(.N(DEPTH)) u_iss_pick (
        .req (elig),
        .gnt (iss_gnt),
        .vld (iss_any)
    );

    // Free-slot view is registered state only, so a slot issued this cycle
    // only becomes visible as free on the next cycle.
    assign disp_ready = free_vld;
    assign iss_valid  = iss_any;
    assign disp_fire  = disp_valid && free_vld;
    assign iss_fire   = iss_any && iss_ready;

    // A dispatched operand that is waiting on the tag being broadcast right
    // now is captured immediately; otherwise that wakeup would be missed.
    always_comb begin
        cap1    = disp_rdy1 || (cdb_valid && (disp_tag1 == cdb_tag));
        cap2    = disp_rdy2 || (cdb_valid && (disp_tag2 == cdb_tag));
        capval1 = disp_rdy1 ? disp_val1 : cdb_data;
        capval2 = disp_rdy2 ? disp_val2 : cdb_data;
    end

    // Issue mux: one-hot AND-OR, all zero when nothing is eligible.
    always_comb begin
        iss_src1 = '0;
        iss_src2 = '0;
        iss_aluc = '0;
        iss_dst  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_gnt[i]) begin
`ifdef ALU_RS_FWD_EN
                iss_src1 = hit1[i] ? cdb_data : ent_q[i].val1;
                iss_src2 = hit2[i] ? cdb_data : ent_q[i].val2;
`else
                iss_src1 = ent_q[i].val1;
                iss_src2 = ent_q[i].val2;
`endif
                iss_aluc = ent_q[i].aluc;
                iss_dst  = ent_q[i].dst;
            end
        end
    end

    // Only busy bits are reset; payload fields are don't-care while free.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire && free_gnt[i]) begin
                    ent_q[i].busy <= 1'b1;
                    ent_q[i].aluc <= disp_aluc;
                    ent_q[i].dst  <= disp_dst;
                    ent_q[i].rdy1 <= cap1;
                    ent_q[i].val1 <= capval1;
                    ent_q[i].tag1 <= disp_tag1;
                    ent_q[i].rdy2 <= cap2;
                    ent_q[i].val2 <= capval2;
                    ent_q[i].tag2 <= disp_tag2;
                end else begin
                    if (hit1[i]) begin
                        ent_q[i].rdy1 <= 1'b1;
                        ent_q[i].val1 <= cdb_data;
                    end
                    if (hit2[i]) begin
                        ent_q[i].rdy2 <= 1'b1;
                        ent_q[i].val2 <= cdb_data;
                    end
                    if (iss_fire && iss_gnt[i]) begin
                        ent_q[i].busy <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios followed by random traffic against a reference model.
// Latency: n/a.
// Backpressure: iss_ready driven directly and randomly.
module tb_alu_rs;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [3:0]        disp_aluc;
    logic [TAG_W-1:0]  disp_dst;
    logic              disp_rdy1;
    logic              disp_rdy2;
    logic [DATA_W-1:0] disp_val1;
    logic [DATA_W-1:0] disp_val2;
    logic [TAG_W-1:0]  disp_tag1;
    logic [TAG_W-1:0]  disp_tag2;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              iss_valid;
    logic              iss_ready;
    logic [DATA_W-1:0] iss_src1;
    logic [DATA_W-1:0] iss_src2;
    logic [3:0]        iss_aluc;
    logic [TAG_W-1:0]  iss_dst;

    always #5 clk = ~clk;

    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_aluc  (disp_aluc),
        .disp_dst   (disp_dst),
        .disp_rdy1  (disp_rdy1),
        .disp_rdy2  (disp_rdy2),
        .disp_val1  (disp_val1),
        .disp_val2  (disp_val2),
        .disp_tag1  (disp_tag1),
        .disp_tag2  (disp_tag2),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_src1   (iss_src1),
        .iss_src2   (iss_src2),
        .iss_aluc   (iss_aluc),
        .iss_dst    (iss_dst)
    );

    // Reference model: an array of slots holding the op as the ALU will see it.
    typedef struct {
        bit          busy;
        logic [3:0]  aluc;
        logic [3:0]  dst;
        bit          r1;
        logic [31:0] v1;
        logic [3:0]  t1;
        bit          r2;
        logic [31:0] v2;
        logic [3:0]  t2;
    } m_ent_t;

    m_ent_t m [DEPTH];

    int tests = 0;
    int fails = 0;

    logic        o_disp_ready;
    logic        o_iss_valid;
    logic [31:0] o_src1;
    logic [31:0] o_src2;
    logic [3:0]  o_aluc;
    logic [3:0]  o_dst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit op_ok(input bit r, input logic [3:0] t);
`ifdef ALU_RS_FWD_EN
        return r || (cdb_valid && t == cdb_tag);
`else
        return r;
`endif
    endfunction

    function automatic logic [31:0] op_val(input bit r, input logic [31:0] v);
        return r ? v : cdb_data;
    endfunction

    function automatic int m_pick_iss();
        for (int i = 0; i < DEPTH; i++)
            if (m[i].busy && op_ok(m[i].r1, m[i].t1) && op_ok(m[i].r2, m[i].t2))
                return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < DEPTH; i++)
            if (!m[i].busy) return i;
        return -1;
    endfunction

    // One clock: compare outputs for the current inputs, then advance the model across the edge.
    task automatic step();
        int ie;
        int fr;
        #1;
        ie = m_pick_iss();
        fr = m_free();
        chk("disp_ready", 32'(disp_ready), 32'(fr >= 0));
        chk("iss_valid", 32'(iss_valid), 32'(ie >= 0));
        chk("iss_src1", iss_src1, (ie >= 0) ? op_val(m[ie].r1, m[ie].v1) : 32'h0);
        chk("iss_src2", iss_src2, (ie >= 0) ? op_val(m[ie].r2, m[ie].v2) : 32'h0);
        chk("iss_aluc", 32'(iss_aluc), (ie >= 0) ? 32'(m[ie].aluc) : 32'h0);
        chk("iss_dst", 32'(iss_dst), (ie >= 0) ? 32'(m[ie].dst) : 32'h0);
        o_disp_ready = disp_ready;
        o_iss_valid  = iss_valid;
        o_src1       = iss_src1;
        o_src2       = iss_src2;
        o_aluc       = iss_aluc;
        o_dst        = iss_dst;
        @(posedge clk);
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].busy && cdb_valid) begin
                    if (!m[i].r1 && m[i].t1 == cdb_tag) begin m[i].r1 = 1; m[i].v1 = cdb_data; end
                    if (!m[i].r2 && m[i].t2 == cdb_tag) begin m[i].r2 = 1; m[i].v2 = cdb_data; end
                end
            end
            if (iss_ready && ie >= 0) m[ie].busy = 0;
            if (disp_valid && fr >= 0) begin
                m[fr].busy = 1;
                m[fr].aluc = disp_aluc;
                m[fr].dst  = disp_dst;
                m[fr].t1   = disp_tag1;
                m[fr].t2   = disp_tag2;
                m[fr].r1   = disp_rdy1 || (cdb_valid && disp_tag1 == cdb_tag);
                m[fr].v1   = disp_rdy1 ? disp_val1 : cdb_data;
                m[fr].r2   = disp_rdy2 || (cdb_valid && disp_tag2 == cdb_tag);
                m[fr].v2   = disp_rdy2 ? disp_val2 : cdb_data;
            end
        end
        #1;
    endtask

    task automatic disp(input logic [3:0] a, input logic [3:0] d,
                        input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        disp_valid = 1'b1;
        disp_aluc  = a;
        disp_dst   = d;
        disp_rdy1  = r1;
        disp_val1  = v1;
        disp_tag1  = t1;
        disp_rdy2  = r2;
        disp_val2  = v2;
        disp_tag2  = t2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; iss_ready = 1'b0;
        disp_valid = 1'b0; disp_aluc = '0; disp_dst = '0;
        disp_rdy1 = 1'b0; disp_rdy2 = 1'b0; disp_val1 = '0; disp_val2 = '0;
        disp_tag1 = '0; disp_tag2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        step();
        chk("rst_disp_ready", 32'(o_disp_ready), 32'd1);
        chk("rst_iss_valid", 32'(o_iss_valid), 32'd0);
        chk("rst_src1", o_src1, 32'h0);
        chk("rst_src2", o_src2, 32'h0);
        chk("rst_aluc", 32'(o_aluc), 32'h0);
        chk("rst_dst", 32'(o_dst), 32'h0);

        // Both operands ready: issue one cycle after dispatch
        disp(4'b0000, 4'd1, 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1, 32'h1, 4'd0);
        step();
        chk("ready_same_cycle", 32'(o_iss_valid), 32'd0);
        disp_valid = 1'b0; iss_ready = 1'b1;
        step();
        chk("ready_iss_valid", 32'(o_iss_valid), 32'd1);
        chk("ready_src1", o_src1, 32'hFFFF_FFFF);
        chk("ready_src2", o_src2, 32'h1);
        chk("ready_aluc", 32'(o_aluc), 32'h0);
        chk("ready_dst", 32'(o_dst), 32'h1);
        step();
        chk("ready_freed", 32'(o_iss_valid), 32'd0);

        // Operand 1 waits on tag 5, broadcast two cycles after dispatch
        disp(4'b0011, 4'd2, 1'b0, 32'h0, 4'd5, 1'b1, 32'h1, 4'd0);
        step();
        disp_valid = 1'b0;
        step();
        chk("wake_waiting", 32'(o_iss_valid), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h8000_0000;
        step();
`ifdef ALU_RS_FWD_EN
        chk("wake_fwd_valid", 32'(o_iss_valid), 32'd1);
        chk("wake_fwd_src1", o_src1, 32'h8000_0000);
`else
        chk("wake_bcast_cycle", 32'(o_iss_valid), 32'd0);
`endif
        cdb_valid = 1'b0;
        step();
`ifdef ALU_RS_FWD_EN
        chk("wake_after_fwd", 32'(o_iss_valid), 32'd0);
`else
        chk("wake_valid", 32'(o_iss_valid), 32'd1);
        chk("wake_src1", o_src1, 32'h8000_0000);
        chk("wake_aluc", 32'(o_aluc), 32'h3);
`endif

        // Wakeup in the same cycle as dispatch
        disp(4'b0101, 4'd3, 1'b1, 32'h7, 4'd0, 1'b0, 32'h0, 4'd3);
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'hCCCC_CCCC;
        step();
        chk("samecyc_wake_disp", 32'(o_iss_valid), 32'd0);
        disp_valid = 1'b0; cdb_valid = 1'b0;
        step();
        chk("samecyc_valid", 32'(o_iss_valid), 32'd1);
        chk("samecyc_src2", o_src2, 32'hCCCC_CCCC);
        chk("samecyc_src1", o_src1, 32'h7);

        // Fill all entries, extra dispatch dropped, release one
        iss_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            disp(4'(k), 4'(4 + k), 1'b1, 32'(100 + k), 4'd0, 1'b1, 32'(200 + k), 4'd0);
            step();
        end
        disp(4'd9, 4'd15, 1'b1, 32'd99, 4'd0, 1'b1, 32'd99, 4'd0);
        step();
        chk("full_disp_ready", 32'(o_disp_ready), 32'd0);
        disp_valid = 1'b0; iss_ready = 1'b1;
        step();
        chk("full_release_dst", 32'(o_dst), 32'd4);
        chk("full_release_ready", 32'(o_disp_ready), 32'd0);
        iss_ready = 1'b0;
        step();
        chk("full_after_release", 32'(o_disp_ready), 32'd1);
        chk("full_next_dst", 32'(o_dst), 32'd5);

        // Flush with three busy entries and a concurrent dispatch
        flush = 1'b1;
        disp(4'd1, 4'd14, 1'b1, 32'h55, 4'd0, 1'b1, 32'h66, 4'd0);
        step();
        flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b1;
        step();
        chk("flush_iss_valid", 32'(o_iss_valid), 32'd0);
        chk("flush_disp_ready", 32'(o_disp_ready), 32'd1);

        // Entries 0 and 2 woken by the same broadcast; priority and hold under backpressure
        iss_ready = 1'b0;
        disp(4'd1, 4'd10, 1'b0, 32'h0, 4'd6, 1'b1, 32'h11, 4'd0);
        step();
        disp(4'd2, 4'd11, 1'b0, 32'h0, 4'd9, 1'b1, 32'h22, 4'd0);
        step();
        disp(4'd4, 4'd12, 1'b0, 32'h0, 4'd6, 1'b1, 32'h33, 4'd0);
        step();
        disp_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h1234;
        step();
`ifdef ALU_RS_FWD_EN
        chk("prio_fwd_dst", 32'(o_dst), 32'd10);
`else
        chk("prio_bcast_valid", 32'(o_iss_valid), 32'd0);
`endif
        cdb_valid = 1'b0;
        step();
        chk("prio_first_dst", 32'(o_dst), 32'd10);
        chk("prio_first_src1", o_src1, 32'h1234);
        chk("prio_first_src2", o_src2, 32'h11);
        step();
        chk("prio_hold_dst", 32'(o_dst), 32'd10);
        chk("prio_hold_src2", o_src2, 32'h11);
        iss_ready = 1'b1;
        step();
        chk("prio_hs_dst", 32'(o_dst), 32'd10);
        step();
        chk("prio_second_dst", 32'(o_dst), 32'd12);
        chk("prio_second_src2", o_src2, 32'h33);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            disp_valid = 1'($urandom_range(0, 1));
            disp_aluc  = 4'($urandom);
            disp_dst   = 4'($urandom);
            disp_rdy1  = 1'($urandom_range(0, 1));
            disp_rdy2  = 1'($urandom_range(0, 1));
            disp_val1  = $urandom;
            disp_val2  = $urandom;
            disp_tag1  = 4'($urandom);
            disp_tag2  = 4'($urandom);
            cdb_valid  = 1'($urandom_range(0, 1));
            cdb_tag    = 4'($urandom);
            cdb_data   = $urandom;
            iss_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
